// File: rtl/data_memory_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_memory_responder                                                    |
// | Byte-maskable data SRAM plus machine-timer peripheral, 1-cycle reads.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_memory_responder #(
    parameter int SRAM_ADDR_W = 9,
    parameter int PRESCALE    = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  wmask_i,
    input  logic        wen_i,
    input  logic        ren_i,
    output logic [31:0] read_data_o,
    output logic        timer_irq_o
);
    localparam int                 c_DEPTH    = 2 ** SRAM_ADDR_W;
    localparam int                 c_PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
    localparam logic [2:0]         c_SEL_MTIME_LO = 3'd0;
    localparam logic [2:0]         c_SEL_MTIME_HI = 3'd1;
    localparam logic [2:0]         c_SEL_CMP_LO   = 3'd2;
    localparam logic [2:0]         c_SEL_CMP_HI   = 3'd3;
    localparam logic [2:0]         c_SEL_CTRL     = 3'd4;
    localparam logic [2:0]         c_SEL_SCRATCH  = 3'd5;

    logic [31:0]        r_mem [c_DEPTH];
    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic [1:0]         r_ctrl;
    logic [31:0]        r_scratch;
    logic [31:0]        r_shadow_hi;
    logic [c_PRE_W-1:0] r_pre_cnt;
    logic [31:0]        r_read_data;
    logic               r_irq;

    logic                   w_is_periph;
    logic [2:0]             w_sel;
    logic [SRAM_ADDR_W-1:0] w_sram_idx;
    logic                   w_store;
    logic                   w_sram_we;
    logic                   w_per_we;
    logic                   w_tick;
    logic                   w_wr_mtime_lo;
    logic                   w_wr_mtime_hi;
    logic                   w_wr_ctrl;
    logic [63:0]            w_mtime_inc;
    logic [63:0]            w_mtime_next;
    logic [31:0]            w_rdata;
    logic                   w_unused_addr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_w;
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) res[8*n +: 8] = new_w[8*n +: 8];
        end
        return res;
    endfunction

    assign w_is_periph   = addr_i[11];
    assign w_sel         = addr_i[4:2];
    assign w_sram_idx    = addr_i[SRAM_ADDR_W+1:2];
    assign w_unused_addr = &{1'b0, addr_i};

    assign w_store   = ~wen_i & (wmask_i != 4'b0000);
    assign w_sram_we = w_store & ~w_is_periph & reset_i;
    assign w_per_we  = w_store & w_is_periph;

    assign w_tick        = r_ctrl[0] & (r_pre_cnt == c_PRE_LAST);
    assign w_wr_mtime_lo = w_per_we & (w_sel == c_SEL_MTIME_LO);
    assign w_wr_mtime_hi = w_per_we & (w_sel == c_SEL_MTIME_HI);
    assign w_wr_ctrl     = w_per_we & (w_sel == c_SEL_CTRL) & wmask_i[0];

    // A software write to either half wins over the increment for that cycle.
    assign w_mtime_inc  = (w_tick & ~(w_wr_mtime_lo | w_wr_mtime_hi)) ? r_mtime + 64'd1 : r_mtime;
    assign w_mtime_next = {w_wr_mtime_hi ? merge_bytes(w_mtime_inc[63:32], data_i, wmask_i)
                                         : w_mtime_inc[63:32],
                           w_wr_mtime_lo ? merge_bytes(w_mtime_inc[31:0], data_i, wmask_i)
                                         : w_mtime_inc[31:0]};

    always_comb begin
        w_rdata = 32'd0;
        if (!w_is_periph) begin
            w_rdata = r_mem[w_sram_idx];
        end else begin
            case (w_sel)
                c_SEL_MTIME_LO: w_rdata = r_mtime[31:0];
                c_SEL_MTIME_HI: w_rdata = r_shadow_hi;
                c_SEL_CMP_LO:   w_rdata = r_mtimecmp[31:0];
                c_SEL_CMP_HI:   w_rdata = r_mtimecmp[63:32];
                c_SEL_CTRL:     w_rdata = {30'd0, r_ctrl};
                c_SEL_SCRATCH:  w_rdata = r_scratch;
                default:        w_rdata = 32'd0;
            endcase
        end
    end

    // SRAM contents survive reset; reads sample the array before this edge's write.
    always_ff @(posedge clk_i) begin
        if (w_sram_we) begin
            for (int n = 0; n < 4; n++) begin
                if (wmask_i[n]) r_mem[w_sram_idx][8*n +: 8] <= data_i[8*n +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_read_data <= 32'd0;
            r_irq       <= 1'b0;
            r_mtime     <= 64'd0;
            r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_ctrl      <= 2'b00;
            r_scratch   <= 32'd0;
            r_shadow_hi <= 32'd0;
            r_pre_cnt   <= '0;
        end else begin
            if (ren_i) r_read_data <= w_rdata;
            if (ren_i && w_is_periph && (w_sel == c_SEL_MTIME_LO)) r_shadow_hi <= r_mtime[63:32];

            r_mtime <= w_mtime_next;

            if (w_wr_ctrl)      r_pre_cnt <= '0;
            else if (r_ctrl[0]) r_pre_cnt <= w_tick ? '0 : r_pre_cnt + c_PRE_W'(1);

            if (w_wr_ctrl) r_ctrl <= data_i[1:0];
            if (w_per_we && (w_sel == c_SEL_CMP_LO))
                r_mtimecmp[31:0] <= merge_bytes(r_mtimecmp[31:0], data_i, wmask_i);
            if (w_per_we && (w_sel == c_SEL_CMP_HI))
                r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], data_i, wmask_i);
            if (w_per_we && (w_sel == c_SEL_SCRATCH))
                r_scratch <= merge_bytes(r_scratch, data_i, wmask_i);

            r_irq <= r_ctrl[1] & (r_mtime >= r_mtimecmp);
        end
    end

    assign read_data_o = r_read_data;
    assign timer_irq_o = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_memory_responder                                                 |
// | Randomised scoreboard bench with an edge-count based timer model.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_memory_responder;
    localparam int          SRAM_ADDR_W = 9;
    localparam int          PRESCALE    = 1;
    localparam logic [31:0] c_PER       = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] data_i = 32'd0;
    logic [3:0]  wmask_i = 4'd0;
    logic        wen_i = 1'b1;
    logic        ren_i = 1'b0;
    logic [31:0] read_data_o;
    logic        timer_irq_o;

    always #5 clk = ~clk;

    data_memory_responder #(.SRAM_ADDR_W(SRAM_ADDR_W), .PRESCALE(PRESCALE)) dut (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .data_i(data_i),
        .wmask_i(wmask_i), .wen_i(wen_i), .ren_i(ren_i),
        .read_data_o(read_data_o), .timer_irq_o(timer_irq_o)
    );

    int     total = 0;
    int     bad   = 0;
    longint ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    // Reference model. mtime is held as a value fixed after edge m_val_edge;
    // while enabled, it gains one per PRESCALE edges counted from m_en_edge.
    logic [31:0] m_mem [512];
    logic [63:0] m_val;
    longint      m_val_edge, m_en_edge;
    logic [1:0]  m_ctrl;
    logic [63:0] m_cmp;
    logic [31:0] m_scratch, m_shadow;

    logic [31:0] exp_q [$];
    string       name_q [$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int n = 0; n < 4; n++) if (m[n]) r[8*n +: 8] = d[8*n +: 8];
        return r;
    endfunction

    // mtime as seen by combinational logic just before edge f.
    function automatic logic [63:0] mtime_before(longint f);
        if (!m_ctrl[0]) return m_val;
        return m_val + 64'((f - 1 - m_en_edge) / PRESCALE - (m_val_edge - m_en_edge) / PRESCALE);
    endfunction

    function automatic logic exp_irq();
        return m_ctrl[1] && (mtime_before(ecount) >= m_cmp);
    endfunction

    function automatic void model_reset();
        m_val = 64'd0; m_val_edge = ecount; m_en_edge = ecount; m_ctrl = 2'b00;
        m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_scratch = 32'd0; m_shadow = 32'd0;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a, longint e);
        logic [63:0] t;
        if (!a[11]) return m_mem[a[10:2]];
        case (a[4:2])
            3'd0: begin t = mtime_before(e); m_shadow = t[63:32]; return t[31:0]; end
            3'd1: return m_shadow;
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_ctrl};
            3'd5: return m_scratch;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] m, longint e);
        logic [63:0] t;
        if (m == 4'd0) return;
        if (!a[11]) begin
            m_mem[a[10:2]] = merge(m_mem[a[10:2]], d, m);
            return;
        end
        case (a[4:2])
            3'd0, 3'd1: begin
                t = mtime_before(e);
                if (a[4:2] == 3'd0) t[31:0] = merge(t[31:0], d, m);
                else                t[63:32] = merge(t[63:32], d, m);
                m_val = t; m_val_edge = e;
            end
            3'd2: m_cmp[31:0]  = merge(m_cmp[31:0], d, m);
            3'd3: m_cmp[63:32] = merge(m_cmp[63:32], d, m);
            3'd4: if (m[0]) begin
                m_val = mtime_before(e + 1); m_val_edge = e; m_en_edge = e; m_ctrl = d[1:0];
            end
            3'd5: m_scratch = merge(m_scratch, d, m);
            default: ;
        endcase
    endfunction

    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic we_n, input logic re, input string nm);
        longint e;
        e = ecount + 1;
        addr_i = a; data_i = d; wmask_i = m; wen_i = we_n; ren_i = re;
        if (re) begin
            exp_q.push_back(model_read(a, e));
            name_q.push_back(nm);
        end
        if (!we_n) model_write(a, d, m, e);
        @(posedge clk); #1;
        wen_i = 1'b1; ren_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(a, d, 4'hF, 1'b0, 1'b0, "");
    endtask

    task automatic rd(input logic [31:0] a, input string nm);
        cycle(a, 32'd0, 4'h0, 1'b1, 1'b1, nm);
    endtask

    task automatic idle();
        cycle(addr_i, 32'd0, 4'h0, 1'b1, 1'b0, "");
    endtask

    // Scoreboard monitor: every accepted read is checked one cycle later.
    always @(posedge clk) begin
        if (reset_i && ren_i) begin
            #2;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL read_unexpected: got %h with no expected value", read_data_o);
            end else begin
                check(name_q.pop_front(), read_data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check("rst_read_data", read_data_o, 32'd0);
        check("rst_irq", timer_irq_o, 1'b0);
        reset_i = 1'b1;
        for (int s = 0; s < 8; s++) rd(c_PER | 32'(s << 2), "rst_periph");

        wr(32'h10, 32'hDEADBEEF);
        rd(32'h10, "sram_full_word");
        idle();
        check("read_hold", read_data_o, 32'hDEADBEEF);

        wr(32'h20, 32'h11223344);
        cycle(32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, "");
        rd(32'h20, "sram_mask_merge");
        idle();
        check("mask_merge_value", read_data_o, 32'h11BB33DD);

        wr(32'h30, 32'h0);
        cycle(32'h30, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b1, "read_first_old");
        rd(32'h30, "read_first_new");

        for (int i = 0; i < 16; i++) wr(32'((64 + i) << 2), $urandom);
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                a[11] = 1'b0;
                a[10:2] = 9'(64 + $urandom_range(0, 15));
            end else begin
                a[11] = 1'b1;
            end
            cycle(a, $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
                  a[11] ? "rand_periph_rd" : "rand_sram_rd");
        end

        wr(c_PER | 32'h10, 32'h0);
        wr(c_PER | 32'h4, 32'h0);
        wr(c_PER | 32'h0, 32'h0);
        wr(c_PER | 32'hC, 32'h0);
        wr(c_PER | 32'h8, 32'd10);
        wr(c_PER | 32'h10, 32'h3);
        for (int k = 0; k < 14; k++) begin
            idle();
            check("irq_track", timer_irq_o, exp_irq());
        end
        check("irq_high", timer_irq_o, 1'b1);
        wr(c_PER | 32'h8, 32'd100);
        check("irq_still_high", timer_irq_o, 1'b1);
        idle();
        check("irq_dropped", timer_irq_o, exp_irq());
        check("irq_low", timer_irq_o, 1'b0);

        wr(c_PER | 32'h10, 32'h0);
        wr(c_PER | 32'h4, 32'h0);
        wr(c_PER | 32'h0, 32'hFFFFFFFF);
        wr(c_PER | 32'h10, 32'h1);
        rd(c_PER | 32'h0, "snap_lo");
        repeat (5) idle();
        rd(c_PER | 32'h4, "snap_hi_latched");
        rd(c_PER | 32'h0, "snap_lo_after_carry");
        rd(c_PER | 32'h4, "snap_hi_carried");
        cycle(c_PER | 32'h0, 32'h0, 4'b1110, 1'b0, 1'b0, "");
        rd(c_PER | 32'h0, "mtime_write_suppresses_tick");

        addr_i = 32'h10; ren_i = 1'b1; reset_i = 1'b0;
        @(posedge clk); #1;
        ren_i = 1'b0;
        @(posedge clk); #1;
        model_reset();
        reset_i = 1'b1;
        check("midrst_read_data", read_data_o, 32'd0);
        check("midrst_irq", timer_irq_o, 1'b0);
        rd(c_PER | 32'h0, "midrst_mtime_lo");
        rd(c_PER | 32'h10, "midrst_ctrl");
        rd(32'h10, "midrst_sram_kept");
        idle();
        check("midrst_sram_value", read_data_o, 32'hDEADBEEF);

        repeat (3) idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Responder end of the core's data-memory port. It accepts word-aligned address, write data and byte write mask from the load/store unit and services two regions selected by addr_i[11]:
- addr_i[11]=0: internal byte-maskable SRAM.
- addr_i[11]=1: a memory-mapped machine-timer peripheral.

Read data is returned with a fixed one-cycle latency, which the load/store unit's MEM stage consumes directly.

Parameters:
SRAM_ADDR_W, 9, word-address width of the SRAM (depth 2**SRAM_ADDR_W words, indexed by addr_i[SRAM_ADDR_W+1:2]; must be <=9)
PRESCALE, 1, clock cycles per mtime increment (>=1)

Ports:
clk_i  input  1  clock, all logic on rising edge
reset_i  input  1  synchronous active-low reset
addr_i  input  32  word-aligned byte address; [1:0] ignored, [31:12] ignored (aliasing)
data_i  input  32  write data, already lane-shifted by requester
wmask_i  input  4  byte-lane write enables, bit n = data_i[8n+7:8n]
wen_i  input  1  active-low write strobe (0 = store this cycle)
ren_i  input  1  active-high read strobe
read_data_o  output  32  registered read data, valid the cycle after ren_i
timer_irq_o  output  1  registered machine timer interrupt

Behaviour:
- Reset (reset_i=0 at a clock edge):
  - read_data_o=0, timer_irq_o=0.
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl=0, scratch=0, shadow_hi=0, prescale counter=0.
  - SRAM contents not reset.
  - Reset dominates any same-cycle access.
- Write: when wen_i=0, each lane with wmask_i[n]=1 is written at the edge; lanes with wmask_i[n]=0 are unchanged. wmask_i=0 with wen_i=0 is a no-op.
- Read:
  - When ren_i=1, read_data_o loads the selected word at the edge.
  - When ren_i=0, read_data_o holds its previous value.
  - Latency is exactly 1 cycle.
- Read and write to the same word in the same cycle are read-first: read_data_o returns the pre-write value.
- Peripheral map (addr_i[11]=1, register select addr_i[4:2]):
  - 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi, 4 ctrl, 5 scratch.
  - ctrl bit0 = count enable, bit1 = irq enable; ctrl bits [31:2] read 0.
  - Selects 6–7 read 0; writes to them are ignored.
  - Byte masks apply to every peripheral register.
- mtime snapshot:
  - A read of mtime_lo also latches mtime[63:32] into shadow_hi in the same edge.
  - A read of mtime_hi returns shadow_hi, not the live value.
  - A write to mtime_lo/mtime_hi writes the live counter and does not touch shadow_hi.
- Counter:
  - With ctrl.bit0=1, the prescale counter counts 0..PRESCALE-1. mtime increments by 1 in the cycle the counter is at PRESCALE-1, and the counter wraps to 0.
  - With ctrl.bit0=0, the counter and mtime hold.
  - mtime wraps from 2**64-1 to 0.
  - A software write to a mtime half in the same cycle as an increment: the written bytes take the written value, and the increment is suppressed for that cycle.
  - A write to ctrl.bit0 resets the prescale counter to 0.
- Interrupt:
  - timer_irq_o is registered: next value = ctrl.bit1 & (mtime >= mtimecmp), unsigned 64-bit, evaluated on current-cycle register values.
  - The interrupt clears one cycle after mtimecmp is raised above mtime or irq enable is cleared.

Test Plan:
- Reset then SRAM store at 0x0000_0010, data 0xDEADBEEF, wmask 4'b1111; read 0x10 -> read_data_o=0xDEADBEEF exactly one cycle after ren_i.
- Byte-mask merge: word at 0x20 = 0x11223344; store data 0xAABBCCDD, wmask 4'b0101; read -> 0x11BB33DD.
- Same-cycle read+write at 0x30 (old 0x0, new 0x5A5A5A5A) -> read_data_o=0x0; next read -> 0x5A5A5A5A.
- Timer, PRESCALE=1:
  - Write mtimecmp_hi=0, mtimecmp_lo=10, then ctrl=3.
  - mtime reaches 10 after 10 counting cycles, and timer_irq_o rises the following cycle.
  - Writing mtimecmp_lo=100 drops timer_irq_o one cycle later.
- Snapshot and wrap:
  - Write mtime_hi=0, mtime_lo=0xFFFFFFFF, ctrl=1.
  - Read mtime_lo (value shows 0xFFFFFFFF or later), then several cycles later read mtime_hi -> returns the value latched at the lo read, not the post-carry value.
- Reset mid-operation: assert reset_i=0 during a counting timer and a pending SRAM read -> read_data_o=0, timer_irq_o=0, mtime=0; previously written SRAM word still reads back its value after reset.
